// File: rtl/trace_checker_pkg.sv
// Shared types and constants for the trace checker.
// Holds the run-state encoding and channel numbering.
package trace_checker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_e;

   // Channel 0 of every trace row is the program counter.
   localparam int unsigned PC_CH = 0;

   function automatic logic is_term(input state_e s);
      return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
   endfunction

endpackage

// File: rtl/trace_mem.sv
// Expected-trace table: one row per retired step.
// Synchronous write, asynchronous read at the compare index.
module trace_mem #(
   parameter int W     = 96,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   // Row write from the loader port.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/trace_checker.sv
// Compares observed PC/registers against an expected trace.
// Reports PASS, first FAIL location, or TIMEOUT.
module trace_checker
   import trace_checker_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NCH   = 2,
   parameter int DEPTH = 16,
   parameter int CW    = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CHW  = $clog2(NCH+1),
   localparam int TW   = (NCH+1)*XLEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                step,
   input  logic [XLEN-1:0]     pc_obs,
   input  logic [NCH*XLEN-1:0] reg_obs,
   input  logic [NCH:0]        chan_en,
   input  logic [CW-1:0]       max_cycles,
   input  logic                exp_we,
   input  logic [AW-1:0]       exp_addr,
   input  logic [TW-1:0]       exp_data,
   input  logic [AW:0]         exp_count,
   output logic [CW-1:0]       cycle_cnt,
   output logic [AW-1:0]       entry_idx,
   output logic                done,
   output logic                pass,
   output logic                halt,
   output logic [AW-1:0]       fail_idx,
   output logic [CHW-1:0]      fail_chan
);

   state_e         state_q, state_d;
   logic [CW-1:0]  cyc_q, cyc_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [AW:0]    cnt_q, cnt_d;
   logic [CW-1:0]  max_q, max_d;
   logic [AW-1:0]  fidx_q, fidx_d;
   logic [CHW-1:0] fchan_q, fchan_d;
   logic           done_q, done_d;
   logic           pass_q, pass_d;
   logic           halt_q, halt_d;

   logic           mem_we;
   logic [TW-1:0]  exp_row;
   logic [TW-1:0]  obs_row;
   logic           miss;
   logic [CHW-1:0] miss_ch;
   logic [AW:0]    cnt_in;
   logic           last_hit;
   logic           to_hit;
   logic [CW-1:0]  cyc_inc;

   // The table may only change while no run is comparing against it.
   assign mem_we = exp_we && !rst && (state_q != ST_RUN);

   trace_mem #(
      .W     (TW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (exp_addr),
      .wdata (exp_data),
      .raddr (idx_q),
      .rdata (exp_row)
   );

   assign obs_row = {reg_obs, pc_obs};

   // Lowest enabled mismatching channel; PC wins over registers.
   always_comb begin
      miss    = 1'b0;
      miss_ch = '0;
      for (int k = NCH; k >= 0; k--) begin
         if (chan_en[k] &&
             (obs_row[k*XLEN +: XLEN] != exp_row[k*XLEN +: XLEN])) begin
            miss    = 1'b1;
            miss_ch = CHW'(k);
         end
      end
   end

   assign cnt_in   = (exp_count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH)
                                                  : exp_count;
   assign last_hit = ((AW+1)'(idx_q) + 1'b1) == cnt_q;
   assign to_hit   = (max_q != '0) &&
                     (({1'b0, cyc_q} + 1'b1) == {1'b0, max_q});
   assign cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      fidx_d  = fidx_q;
      fchan_d = fchan_q;
      unique case (state_q)
         ST_RUN: begin
            cyc_d = cyc_inc;
            if (step && miss) begin
               state_d = ST_FAIL;
               fidx_d  = idx_q;
               fchan_d = miss_ch;
            end else if (step && last_hit) begin
               state_d = ST_PASS;
               idx_d   = idx_q + 1'b1;
            end else begin
               if (step) idx_d = idx_q + 1'b1;
               if (to_hit) state_d = ST_TIMEOUT;
            end
         end
         ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
            if (start) begin
               cyc_d   = '0;
               idx_d   = '0;
               fidx_d  = '0;
               fchan_d = '0;
               max_d   = max_cycles;
               cnt_d   = cnt_in;
               state_d = (cnt_in == '0) ? ST_PASS : ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      done_d = is_term(state_d);
      halt_d = is_term(state_d);
      pass_d = (state_d == ST_PASS);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cyc_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         max_q   <= '0;
         fidx_q  <= '0;
         fchan_q <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         fidx_q  <= fidx_d;
         fchan_q <= fchan_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         halt_q  <= halt_d;
      end
   end

   assign cycle_cnt = cyc_q;
   assign entry_idx = idx_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign halt      = halt_q;
   assign fail_idx  = fidx_q;
   assign fail_chan = fchan_q;

endmodule

// File: tb/tb_trace_checker.sv
// Self-checking bench for trace_checker.
// Scenario table, hand sequences and a randomized outcome model.
module tb_trace_checker;

   localparam int XLEN  = 32;
   localparam int NCH   = 2;
   localparam int DEPTH = 16;
   localparam int CW    = 8;
   localparam int AW    = 4;
   localparam int CHW   = 2;
   localparam int TW    = 96;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                step = 1'b0;
   logic [XLEN-1:0]     pc_obs = '0;
   logic [NCH*XLEN-1:0] reg_obs = '0;
   logic [NCH:0]        chan_en = '0;
   logic [CW-1:0]       max_cycles = '0;
   logic                exp_we = 1'b0;
   logic [AW-1:0]       exp_addr = '0;
   logic [TW-1:0]       exp_data = '0;
   logic [AW:0]         exp_count = '0;
   logic [CW-1:0]       cycle_cnt;
   logic [AW-1:0]       entry_idx;
   logic                done, pass, halt;
   logic [AW-1:0]       fail_idx;
   logic [CHW-1:0]      fail_chan;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] tab [DEPTH][3];

   trace_checker #(
      .XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .CW(CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .step       (step),
      .pc_obs     (pc_obs),
      .reg_obs    (reg_obs),
      .chan_en    (chan_en),
      .max_cycles (max_cycles),
      .exp_we     (exp_we),
      .exp_addr   (exp_addr),
      .exp_data   (exp_data),
      .exp_count  (exp_count),
      .cycle_cnt  (cycle_cnt),
      .entry_idx  (entry_idx),
      .done       (done),
      .pass       (pass),
      .halt       (halt),
      .fail_idx   (fail_idx),
      .fail_chan  (fail_chan)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         count;
      int         maxc;
      logic [2:0] en;
      int         err_entry;
      logic [2:0] err_mask;
      int         nsteps;
      int         run;
      logic       x_done;
      logic       x_pass;
      int         x_cyc;
      int         x_idx;
      int         x_fidx;
      int         x_fchan;
   } vec_t;

   vec_t rows [12];

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic x_done,
                            input logic x_pass, input int x_cyc,
                            input int x_idx, input int x_fidx,
                            input int x_fchan);
      check({tag, " done"},      32'(done),      32'(x_done));
      check({tag, " pass"},      32'(pass),      32'(x_pass));
      check({tag, " halt"},      32'(halt),      32'(x_done));
      check({tag, " cycle_cnt"}, 32'(cycle_cnt), 32'(x_cyc));
      check({tag, " entry_idx"}, 32'(entry_idx), 32'(x_idx));
      check({tag, " fail_idx"},  32'(fail_idx),  32'(x_fidx));
      check({tag, " fail_chan"}, 32'(fail_chan), 32'(x_fchan));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_table();
      for (int i = 0; i < DEPTH; i++) begin
         exp_we   = 1'b1;
         exp_addr = 4'(i);
         exp_data = {tab[i][2], tab[i][1], tab[i][0]};
         @(negedge clk);
      end
      exp_we = 1'b0;
   endtask

   task automatic start_run(input int cnt, input int mx,
                            input logic [2:0] en);
      exp_count  = 5'(cnt);
      max_cycles = 8'(mx);
      chan_en    = en;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drive(input logic s, input logic [31:0] p,
                        input logic [31:0] a0, input logic [31:0] a1);
      step    = s;
      pc_obs  = p;
      reg_obs = {a1, a0};
      @(negedge clk);
      step = 1'b0;
   endtask

   initial begin
      logic [31:0] o [3];
      int st_step [20];
      logic [31:0] st_obs [20][3];

      rows[0]  = '{3, 0, 3'b111, -1, 3'b000, 3, 6,  1, 1, 3, 3, 0, 0};
      rows[1]  = '{3, 0, 3'b111,  1, 3'b100, 3, 6,  1, 0, 2, 1, 1, 2};
      rows[2]  = '{3, 0, 3'b011,  1, 3'b100, 3, 6,  1, 1, 3, 3, 0, 0};
      rows[3]  = '{3, 4, 3'b111, -1, 3'b000, 0, 8,  1, 0, 4, 0, 0, 0};
      rows[4]  = '{3, 3, 3'b111, -1, 3'b000, 3, 6,  1, 1, 3, 3, 0, 0};
      rows[5]  = '{3, 2, 3'b111,  1, 3'b001, 3, 6,  1, 0, 2, 1, 1, 0};
      rows[6]  = '{0, 0, 3'b111, -1, 3'b000, 0, 3,  1, 1, 0, 0, 0, 0};
      rows[7]  = '{31, 0, 3'b111, -1, 3'b000, 20, 20, 1, 1, 16, 0, 0, 0};
      rows[8]  = '{3, 0, 3'b101,  0, 3'b010, 3, 6,  1, 1, 3, 3, 0, 0};
      rows[9]  = '{3, 0, 3'b111,  0, 3'b110, 3, 6,  1, 0, 1, 0, 0, 1};
      rows[10] = '{3, 0, 3'b101,  2, 3'b110, 3, 6,  1, 0, 3, 2, 2, 2};
      rows[11] = '{4, 0, 3'b111, -1, 3'b000, 2, 6,  0, 0, 6, 2, 0, 0};

      for (int i = 0; i < DEPTH; i++) begin
         tab[i][0] = 32'h74 + 32'(4*i);
         tab[i][1] = 32'd5;
         tab[i][2] = 32'd6;
      end

      @(negedge clk);
      @(negedge clk);
      check_all("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      load_table();

      for (int r = 0; r < 12; r++) begin
         do_reset();
         start_run(rows[r].count, rows[r].maxc, rows[r].en);
         for (int c = 0; c < rows[r].run; c++) begin
            for (int k = 0; k < 3; k++) begin
               o[k] = tab[c % DEPTH][k];
               if (c == rows[r].err_entry && rows[r].err_mask[k])
                  o[k] = o[k] ^ 32'd1;
            end
            drive(c < rows[r].nsteps, o[0], o[1], o[2]);
         end
         check_all($sformatf("row%0d", r), rows[r].x_done,
                   rows[r].x_pass, rows[r].x_cyc, rows[r].x_idx,
                   rows[r].x_fidx, rows[r].x_fchan);
      end

      // start and table write while running are both ignored,
      // then rst aborts and a rerun uses the untouched table
      do_reset();
      start_run(3, 0, 3'b111);
      drive(1'b1, tab[0][0], tab[0][1], tab[0][2]);
      drive(1'b0, '0, '0, '0);
      check("run cyc", 32'(cycle_cnt), 32'd2);
      check("run idx", 32'(entry_idx), 32'd1);
      start    = 1'b1;
      exp_we   = 1'b1;
      exp_addr = 4'd1;
      exp_data = {32'hDEAD, 32'hBEEF, 32'hCAFE};
      @(negedge clk);
      start  = 1'b0;
      exp_we = 1'b0;
      check("ign start cyc", 32'(cycle_cnt), 32'd3);
      check("ign start idx", 32'(entry_idx), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all("midrst", 0, 0, 0, 0, 0, 0);
      start_run(3, 0, 3'b111);
      for (int c = 0; c < 3; c++)
         drive(1'b1, tab[c][0], tab[c][1], tab[c][2]);
      check_all("rerun", 1, 1, 3, 3, 0, 0);

      // randomized runs against an outcome model
      for (int t = 0; t < 40; t++) begin
         int cnt, mx, idx, res, cyc, fi, fc;
         logic [2:0] en;
         for (int i = 0; i < DEPTH; i++)
            for (int k = 0; k < 3; k++)
               tab[i][k] = (k == 0) ? $urandom : 32'($urandom_range(0, 3));
         do_reset();
         load_table();
         cnt = $urandom_range(1, 6);
         mx  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
         en  = 3'($urandom_range(0, 7));
         idx = 0; res = 0; cyc = 0; fi = 0; fc = 0;
         for (int c = 0; c < 20; c++) begin
            st_step[c] = ($urandom_range(0, 3) != 0) ? 1 : 0;
            for (int k = 0; k < 3; k++) st_obs[c][k] = tab[idx % DEPTH][k];
            if ($urandom_range(0, 5) == 0) begin
               int ch;
               ch = $urandom_range(0, 2);
               st_obs[c][ch] = st_obs[c][ch] ^ 32'($urandom_range(1, 7));
            end
            if (res == 0) begin
               cyc = c + 1;
               if (st_step[c] != 0) begin
                  int bad;
                  bad = -1;
                  for (int k = 2; k >= 0; k--)
                     if (en[k] && st_obs[c][k] != tab[idx][k]) bad = k;
                  if (bad >= 0) begin
                     res = 2; fi = idx; fc = bad;
                  end else begin
                     idx++;
                     if (idx == cnt) res = 1;
                  end
               end
               if (res == 0 && mx != 0 && cyc == mx) res = 3;
            end
         end
         start_run(cnt, mx, en);
         for (int c = 0; c < 20; c++)
            drive(st_step[c] != 0, st_obs[c][0], st_obs[c][1],
                  st_obs[c][2]);
         check_all($sformatf("rand%0d", t), res != 0, res == 1, cyc,
                   idx, fi, fc);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
